// File: rtl/div_clock_pkg.sv
// -----------------------------------------------------------------------------
// div_clock_pkg
// Shared types and helpers for the divided-clock sequencer:
//   - state_e      : sequencer FSM states
//   - cfg_t        : configuration record (offset, width, divisor)
//   - cfg_is_valid : validity rule for a configuration word
// The record fields are CFG_MAX_W wide. Users zero-extend their CNT_W-bit
// values into it, so the unsigned comparisons give the same result as CNT_W
// arithmetic. CNT_W must not exceed CFG_MAX_W.
// -----------------------------------------------------------------------------
package div_clock_pkg;

  localparam int CFG_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    OFFSET,
    HIGH,
    LOW
  } state_e;

  typedef struct packed {
    logic [CFG_MAX_W-1:0] offset;
    logic [CFG_MAX_W-1:0] width;
    logic [CFG_MAX_W-1:0] divisor;
  } cfg_t;

  // A usable waveform needs a non-empty high phase and a non-empty low phase.
  function automatic logic cfg_is_valid(input cfg_t c);
    return (c.divisor != '0) && (c.width != '0) && (c.width < c.divisor);
  endfunction

endpackage

// File: rtl/div_clock_cfg_regs.sv
// -----------------------------------------------------------------------------
// div_clock_cfg_regs
// Active and shadow configuration storage for div_clock_sequencer.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   i_wr            : accepted and valid configuration word this cycle
//   i_idle          : sequencer is idle (write goes straight to active)
//   i_copy          : LOW->HIGH boundary with a full shadow (shadow -> active)
//   i_cfg           : incoming configuration word
//   o_active        : active configuration
//   o_active_valid  : active configuration has been loaded
//   o_shadow        : shadow configuration
//   o_shadow_full   : shadow holds a pending configuration
// -----------------------------------------------------------------------------
module div_clock_cfg_regs
  import div_clock_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_wr,
  input  logic i_idle,
  input  logic i_copy,
  input  cfg_t i_cfg,
  output cfg_t o_active,
  output logic o_active_valid,
  output cfg_t o_shadow,
  output logic o_shadow_full
);

  cfg_t r_active;
  cfg_t r_shadow;
  logic r_active_valid;
  logic r_shadow_full;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the configuration words are reset as well. There are only a
      // few of them, and this keeps X out of the counter load paths.
      r_active       <= '0;
      r_shadow       <= '0;
      r_active_valid <= 1'b0;
      r_shadow_full  <= 1'b0;
    end else begin
      // The copy takes the old shadow. A word accepted on the same edge
      // overwrites the shadow and leaves it full.
      if (i_copy) begin
        r_active <= r_shadow;
      end
      if (i_wr) begin
        if (i_idle) begin
          r_active       <= i_cfg;
          r_active_valid <= 1'b1;
        end else begin
          r_shadow      <= i_cfg;
          r_shadow_full <= 1'b1;
        end
      end else if (i_copy) begin
        r_shadow_full <= 1'b0;
      end
    end
  end

  assign o_active       = r_active;
  assign o_active_valid = r_active_valid;
  assign o_shadow       = r_shadow;
  assign o_shadow_full  = r_shadow_full;

endmodule

// File: rtl/div_clock_sequencer.sv
// -----------------------------------------------------------------------------
// div_clock_sequencer
// Generates a divided clock: an optional start offset, then repeating periods
// made of a HIGH phase followed by a LOW phase.
// Parameters: CNT_W (counter width), IDLE_LEVEL (clk_out level when not high)
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   run          : level request to generate the waveform
//   cfg_valid    : configuration word offered
//   cfg_ready    : configuration can be accepted this cycle
//   cfg_offset   : cycles from start to the first high phase
//   cfg_width    : high-phase length
//   cfg_divisor  : period length
//   clk_out      : registered divided waveform
//   rise_pulse   : first cycle of each high phase
//   fall_pulse   : first cycle of each low phase
//   busy         : FSM is not idle
//   cfg_err      : sticky, set when an invalid configuration is rejected
// -----------------------------------------------------------------------------
module div_clock_sequencer
  import div_clock_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_divisor,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic             r_cfg_err;

  cfg_t             w_cfg_in;
  cfg_t             w_active;
  cfg_t             w_shadow;
  logic             w_active_valid;
  logic             w_shadow_full;
  logic             w_hs;
  logic             w_cfg_ok;
  logic             w_copy;
  logic [CNT_W-1:0] w_act_offset;
  logic [CNT_W-1:0] w_act_width;
  logic [CNT_W-1:0] w_act_div;
  logic [CNT_W-1:0] w_hi_len;
  logic             w_unused_cfg;

  assign w_cfg_in = '{offset:  CFG_MAX_W'(cfg_offset),
                      width:   CFG_MAX_W'(cfg_width),
                      divisor: CFG_MAX_W'(cfg_divisor)};

  assign w_act_offset = w_active.offset[CNT_W-1:0];
  assign w_act_width  = w_active.width[CNT_W-1:0];
  assign w_act_div    = w_active.divisor[CNT_W-1:0];
  // Upper record bits are always zero; this sink keeps them from being
  // reported as unused.
  assign w_unused_cfg = ^{w_active, w_shadow};

  // Boundary copy: the last LOW cycle before another HIGH while a word is
  // pending.
  assign w_copy = (r_state == LOW) && (r_cnt == '0) && run && w_shadow_full;

  // The shadow frees up on the copy edge, so a new word can be taken there.
  assign cfg_ready = !w_shadow_full || w_copy;
  assign w_hs      = cfg_valid && cfg_ready;
  assign w_cfg_ok  = cfg_is_valid(w_cfg_in);

  // The HIGH phase that starts at a copy boundary uses the incoming width.
  assign w_hi_len = w_copy ? w_shadow.width[CNT_W-1:0] : w_act_width;

  div_clock_cfg_regs u_cfg_regs (
    .CLK            (CLK),
    .RST            (RST),
    .i_wr           (w_hs && w_cfg_ok),
    .i_idle         (r_state == IDLE),
    .i_copy         (w_copy),
    .i_cfg          (w_cfg_in),
    .o_active       (w_active),
    .o_active_valid (w_active_valid),
    .o_shadow       (w_shadow),
    .o_shadow_full  (w_shadow_full)
  );

  // Phase counter holds the cycles left in the current phase minus one.
  always_comb begin
    // NOTE: defaults first, so that every path assigns both outputs and
    // no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (run && w_active_valid) begin
          if (w_act_offset != '0) begin
            w_state_nxt = OFFSET;
            w_cnt_nxt   = w_act_offset - L_ONE;
          end else begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = w_act_width - L_ONE;
          end
        end
      end
      OFFSET: begin
        if (!run) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = w_act_width - L_ONE;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      HIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = w_act_div - w_act_width - L_ONE;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      LOW: begin
        // run is only sampled here, so a period is never cut short.
        if (r_cnt == '0) begin
          if (run) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = w_hi_len - L_ONE;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they line up with the state
  // they describe without an extra cycle of latency.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clk_out <= IDLE_LEVEL;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= (w_state_nxt == HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
      r_rise    <= (w_state_nxt == HIGH) && (r_state != HIGH);
      r_fall    <= (w_state_nxt == LOW) && (r_state != LOW);
      r_busy    <= (w_state_nxt != IDLE);
      r_cfg_err <= r_cfg_err || (w_hs && !w_cfg_ok);
    end
  end

  assign clk_out    = r_clk_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;
  assign cfg_err    = r_cfg_err;

endmodule

// File: doc/div_clock_sequencer.md
DIV_CLOCK_SEQUENCER -- requirements
Module: div_clock_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the offset, width and divisor counters.
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 0, giving the clk_out level while not running.
REQ-003 The block SHALL have input CLK, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have input RST, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input run, 1 bit: level request to generate the divided output.
REQ-006 The block SHALL have input cfg_valid, 1 bit: the configuration word is offered.
REQ-007 The block SHALL have output cfg_ready, 1 bit: a configuration can be accepted this cycle.
REQ-008 The block SHALL have input cfg_offset, CNT_W bits: CLK cycles from start to the first high phase.
REQ-009 The block SHALL have input cfg_width, CNT_W bits: high-phase length in CLK cycles.
REQ-010 The block SHALL have input cfg_divisor, CNT_W bits: period length in CLK cycles.
REQ-011 The block SHALL have output clk_out, 1 bit: the registered divided waveform.
REQ-012 The block SHALL have output rise_pulse, 1 bit: high for one cycle, coincident with the first high-phase cycle.
REQ-013 The block SHALL have output fall_pulse, 1 bit: high for one cycle, coincident with the first low-phase cycle.
REQ-014 The block SHALL have output busy, 1 bit: the FSM is not in IDLE.
REQ-015 The block SHALL have output cfg_err, 1 bit: sticky flag for a rejected configuration.

Function
REQ-016 The FSM SHALL have the states IDLE, OFFSET, HIGH and LOW.
REQ-017 A handshake SHALL occur when cfg_valid and cfg_ready are both 1 on a rising edge.
REQ-018 cfg_ready SHALL be 1 whenever the shadow register is empty.
REQ-019 A configuration with divisor=0, width=0 or width>=divisor SHALL be invalid.
REQ-020 On an invalid configuration, the block SHALL still complete the handshake, set cfg_err, and leave the active and shadow configuration unchanged.
REQ-021 In IDLE, a valid handshake SHALL load the active configuration directly.
REQ-022 In any other state, a valid handshake SHALL load the shadow register and make it full.
REQ-023 The shadow register SHALL be copied to the active configuration at the HIGH-entry boundary, that is, on the LOW->HIGH transition, and is then emptied.
REQ-024 In IDLE with run=1 and a valid active configuration, the FSM SHALL go to OFFSET if offset>0, else to HIGH.
REQ-025 In IDLE with run=1 but no valid active configuration, the FSM SHALL stay in IDLE.
REQ-026 OFFSET SHALL last exactly offset cycles and then go to HIGH.
REQ-027 During OFFSET, clk_out SHALL be IDLE_LEVEL.
REQ-028 HIGH SHALL last exactly width cycles with clk_out=~IDLE_LEVEL, then go to LOW.
REQ-029 LOW SHALL last exactly divisor-width cycles with clk_out=IDLE_LEVEL.
REQ-030 At the end of LOW, the FSM SHALL go to HIGH if run=1, else to IDLE.
REQ-031 Deasserting run SHALL never truncate a period.
REQ-032 Deasserting run during OFFSET SHALL return the FSM to IDLE on the next edge.
REQ-033 clk_out, rise_pulse, fall_pulse and busy SHALL be registered outputs and SHALL reflect the state they describe in the same cycle, with no extra latency.
REQ-034 The first HIGH cycle SHALL appear offset+1 cycles after the edge that samples run=1 in IDLE.
REQ-035 Phase counters SHALL count down from length-1 to 0 and SHALL never wrap.
REQ-036 Lengths SHALL be compared in CNT_W unsigned arithmetic.
REQ-037 When a handshake and a boundary copy occur in the same cycle, the copy SHALL use the old shadow, and the new word SHALL go into the shadow.
REQ-038 cfg_err SHALL be cleared only by RST.

Reset
REQ-039 RST SHALL be synchronous and active-high, and SHALL override all other inputs.
REQ-040 After reset: state=IDLE, clk_out=IDLE_LEVEL, rise_pulse=0, fall_pulse=0, busy=0, cfg_err=0, cfg_ready=1, active configuration invalid, shadow empty.
REQ-041 A reset during any state SHALL return all of REQ-040 on the next edge, with no partial period completed.

Structure
REQ-042 The state encoding enum and the configuration record (offset, width, divisor) SHALL live in the shared package div_clock_pkg.
REQ-043 The configuration validity check SHALL be a package function.
REQ-044 The shadow and active configuration storage SHALL be one sub-module, div_clock_cfg_regs; the FSM and counters SHALL stay in the top module.

Verification
REQ-045 Load offset=3, width=2, divisor=5, then hold run=1 -> clk_out low for 3 cycles, then repeats 11000 with one rise_pulse and one fall_pulse per period.
REQ-046 Load divisor=0, and separately width=5 with divisor=5 -> cfg_err=1, handshake still completes, active configuration unchanged, clk_out stays IDLE_LEVEL.
REQ-047 While running width=2, divisor=5, load width=1, divisor=4 mid-HIGH -> the current period is 5 cycles, the next HIGH uses 1000, and cfg_ready=0 until the copy.
REQ-048 Drop run in the second cycle of HIGH (width=2, divisor=5) -> the period completes, then busy=0 and clk_out=IDLE_LEVEL.
REQ-049 Assert RST in the LOW phase -> the next edge shows all REQ-040 values, and a restart with run=1 reproduces the offset timing exactly.
REQ-050 Offer a new configuration on the same edge as the LOW->HIGH copy with the shadow full -> the old shadow is applied first, the new word is applied at the following boundary.
